// File: rtl/regfile_mp_scoreboard.sv
// Multi-read, dual-write register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass and hardwired-zero register 0.
module regfile_mp_scoreboard #(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 16,
  parameter int NUM_READ   = 3,
  parameter int INIT_INDEX = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0,
  localparam int ADDR_W    = $clog2(WORD_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*WORD_LEN-1:0] rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         wa_en,
  input  logic [ADDR_W-1:0]            wa_addr,
  input  logic [WORD_LEN-1:0]          wa_data,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [WORD_LEN-1:0]          wb_data,
  input  logic                         sclr,
  input  logic [ADDR_W-1:0]            sclr_addr,
  input  logic                         busy_set,
  input  logic [ADDR_W-1:0]            busy_addr,
  output logic [WORD_COUNT-1:0]        busy_vec
);

  logic [WORD_LEN-1:0]   regs_q [WORD_COUNT];
  logic [WORD_LEN-1:0]   regs_d [WORD_COUNT];
  logic [WORD_COUNT-1:0] busy_q;
  logic [WORD_COUNT-1:0] busy_d;

  logic wa_ok;
  logic wb_ok;
  logic sc_ok;
  logic bs_ok;

  // Register 0 swallows every update when hardwired to zero.
  assign wa_ok = wa_en && !(ZERO_REG != 0 && wa_addr == '0);
  assign wb_ok = wb_en && !(ZERO_REG != 0 && wb_addr == '0);
  assign sc_ok = sclr && !(ZERO_REG != 0 && sclr_addr == '0);
  assign bs_ok = busy_set && !(ZERO_REG != 0 && busy_addr == '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wa_ok) begin
      regs_d[wa_addr] = wa_data;
      busy_d[wa_addr] = 1'b0;
    end
    if (wb_ok) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (sc_ok) begin
      regs_d[sclr_addr] = '0;
      busy_d[sclr_addr] = 1'b0;
    end
    if (bs_ok) begin
      busy_d[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        regs_q[i] <= (INIT_INDEX != 0) ? WORD_LEN'(i) : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0]   a;
    logic [WORD_LEN-1:0] d;
    logic                b;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs_q[a];
      b = busy_q[a];
      if (BYPASS != 0) begin
        if (sc_ok && sclr_addr == a) begin
          d = '0;
          b = bs_ok && busy_addr == a;
        end else if (wb_ok && wb_addr == a) begin
          d = wb_data;
          b = bs_ok && busy_addr == a;
        end else if (wa_ok && wa_addr == a) begin
          d = wa_data;
          b = bs_ok && busy_addr == a;
        end
      end
      if (ZERO_REG != 0 && a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*WORD_LEN +: WORD_LEN] = d;
    assign rd_busy[k] = b;
  end

endmodule
